// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  // Receiver FSM states; encoding is visible on the top-level debug port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // PS/2 uses odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-flop synchronizers on clock and data, a
// consecutive-sample glitch filter on the clock, and a one-cycle pulse on
// each filtered-clock falling edge. All flops reset to 1 (idle-high lines).
module ps2_clk_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  // Two-stage synchronizers for the asynchronous PS/2 lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree
  // with it; a matching sample restarts the count. fall marks a 1->0 flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign data_sync = dat_sync[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: decodes 11-bit frames (start, 8 data LSB
// first, odd parity, stop), folds E0/F0 prefixes into is_ext/is_break and
// strobes code_valid for every other good byte. Bad frames pulse frame_err.
// Optional mid-frame watchdog built when PS2_RX_TIMEOUT_EN is defined.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_ext,
  output logic       frame_err,
  output logic [1:0] dbg_state
);

  logic       data_s;
  logic       fall;
  ps2_state_e state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par;
  logic       ext_pending;
  logic       brk_pending;
  logic       to_expire;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_s),
    .fall      (fall)
  );

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Counts cycles since the last edge while a frame is in progress.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE || fall) begin
      to_cnt <= '0;
    end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // An edge on the expiry cycle takes priority over the abort.
  assign to_expire = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // No watchdog: a stalled frame waits indefinitely. Constant false for any
  // legal TIMEOUT_CYC.
  assign to_expire = (TIMEOUT_CYC < 0);
`endif

  // Frame FSM, prefix tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      par         <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      code        <= 8'h00;
      code_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_ext      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= data_s;
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (data_s && ps2_parity_ok(shreg, par)) begin
              if (shreg == PS2_PREFIX_EXT) begin
                ext_pending <= 1'b1;
              end else if (shreg == PS2_PREFIX_BRK) begin
                brk_pending <= 1'b1;
              end else begin
                code        <= shreg;
                is_break    <= brk_pending;
                is_ext      <= ext_pending;
                code_valid  <= 1'b1;
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
              end
            end else begin
              frame_err   <= 1'b1;
              ext_pending <= 1'b0;
              brk_pending <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (to_expire) begin
        state       <= ST_IDLE;
        frame_err   <= 1'b1;
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx. Frames are bit-banged on ps2_clk/ps2_data;
// a negedge monitor logs every code_valid as {is_break,is_ext,code} and
// counts frame_err pulses and any strobe wider than one cycle.
module tb_ps2_frame_rx;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_ext;
  logic       frame_err;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  logic [9:0] obs_q[$];
  int         err_cnt = 0;
  int         cv_wide = 0;
  int         err_wide = 0;
  logic       cv_d = 1'b0;
  logic       fe_d = 1'b0;

  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .is_break   (is_break),
    .is_ext     (is_ext),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor on the inactive edge
  always @(negedge clk) begin
    if (code_valid) obs_q.push_back({is_break, is_ext, code});
    if (frame_err) err_cnt++;
    if (code_valid && cv_d) cv_wide++;
    if (frame_err && fe_d) err_wide++;
    cv_d = code_valid;
    fe_d = frame_err;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_clk  = 1'b1;
    ps2_data = b;
    if (glitch) begin
      tick(6);
      ps2_clk = 1'b0;
      tick(FILTER_LEN - 1);
      ps2_clk = 1'b1;
      tick(6);
    end else begin
      tick(12);
    end
    ps2_clk = 1'b0;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input int glitch_idx, input int nbits);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_idx);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(30);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, -1, 11);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(5);
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    n_cmp++; if (code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h want 00", code); end
    n_cmp++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", code_valid); end
    n_cmp++; if (is_break !== 1'b0) begin n_fail++; $display("FAIL reset_break: got %b want 0", is_break); end
    n_cmp++; if (is_ext !== 1'b0) begin n_fail++; $display("FAIL reset_ext: got %b want 0", is_ext); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_single();
    int o0 = obs_q.size();
    int e0 = err_cnt;
    good(8'h1C);
    n_cmp++; if (obs_q.size() !== o0 + 1) begin n_fail++; $display("FAIL single_count: got %0d want %0d", obs_q.size() - o0, 1); end
    n_cmp++; if (obs_q[o0] !== 10'h01C) begin n_fail++; $display("FAIL single_code: got %h want 01c", obs_q[o0]); end
    n_cmp++; if (err_cnt !== e0) begin n_fail++; $display("FAIL single_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_break();
    int o0 = obs_q.size();
    good(8'hF0);
    n_cmp++; if (obs_q.size() !== o0) begin n_fail++; $display("FAIL break_prefix_silent: got %0d strobes want 0", obs_q.size() - o0); end
    good(8'h1C);
    n_cmp++; if (obs_q.size() !== o0 + 1) begin n_fail++; $display("FAIL break_count: got %0d want 1", obs_q.size() - o0); end
    n_cmp++; if (obs_q[o0] !== 10'h21C) begin n_fail++; $display("FAIL break_code: got %h want 21c", obs_q[o0]); end
  endtask

  task automatic test_ext_break();
    int o0 = obs_q.size();
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    good(8'h1C);
    n_cmp++; if (obs_q.size() !== o0 + 2) begin n_fail++; $display("FAIL extbrk_count: got %0d want 2", obs_q.size() - o0); end
    n_cmp++; if (obs_q[o0] !== 10'h375) begin n_fail++; $display("FAIL extbrk_first: got %h want 375", obs_q[o0]); end
    n_cmp++; if (obs_q[o0+1] !== 10'h01C) begin n_fail++; $display("FAIL extbrk_second: got %h want 01c", obs_q[o0+1]); end
    tick(50);
    n_cmp++; if ({is_break, is_ext, code} !== 10'h01C) begin n_fail++; $display("FAIL extbrk_hold: got %h want 01c", {is_break, is_ext, code}); end
  endtask

  task automatic test_prefix_order();
    int o0 = obs_q.size();
    good(8'hF0);
    good(8'hF0);
    good(8'hE0);
    good(8'hE0);
    n_cmp++; if ({is_break, is_ext, code} !== 10'h01C) begin n_fail++; $display("FAIL prefix_hold: got %h want 01c", {is_break, is_ext, code}); end
    good(8'h5A);
    good(8'hE1);
    n_cmp++; if (obs_q.size() !== o0 + 2) begin n_fail++; $display("FAIL prefix_count: got %0d want 2", obs_q.size() - o0); end
    n_cmp++; if (obs_q[o0] !== 10'h35A) begin n_fail++; $display("FAIL prefix_fe: got %h want 35a", obs_q[o0]); end
    n_cmp++; if (obs_q[o0+1] !== 10'h0E1) begin n_fail++; $display("FAIL prefix_e1: got %h want 0e1", obs_q[o0+1]); end
  endtask

  task automatic test_parity_err();
    int o0 = obs_q.size();
    int e0 = err_cnt;
    good(8'hF0);
    send_frame(8'h29, 1'b1, 1'b1, -1, 11);
    n_cmp++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL parity_err: got %0d want 1", err_cnt - e0); end
    n_cmp++; if (obs_q.size() !== o0) begin n_fail++; $display("FAIL parity_no_code: got %0d want 0", obs_q.size() - o0); end
    good(8'h29);
    n_cmp++; if (obs_q[o0] !== 10'h029) begin n_fail++; $display("FAIL parity_recover: got %h want 029", obs_q[o0]); end
  endtask

  task automatic test_stop_err();
    int o0 = obs_q.size();
    int e0 = err_cnt;
    send_frame(8'h33, 1'b0, 1'b0, -1, 11);
    n_cmp++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL stop_err: got %0d want 1", err_cnt - e0); end
    n_cmp++; if (obs_q.size() !== o0) begin n_fail++; $display("FAIL stop_no_code: got %0d want 0", obs_q.size() - o0); end
  endtask

  task automatic test_glitch();
    int o0 = obs_q.size();
    int e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 3, 11);
    n_cmp++; if (obs_q[o0] !== 10'h01C) begin n_fail++; $display("FAIL glitch_code: got %h want 01c", obs_q[o0]); end
    n_cmp++; if (err_cnt !== e0) begin n_fail++; $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_midframe_reset();
    int o0 = obs_q.size();
    int e0 = err_cnt;
    good(8'hF0);
    send_frame(8'h44, 1'b0, 1'b1, -1, 4);
    n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL midrst_in_data: got %0d want 1", dbg_state); end
    do_reset();
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    n_cmp++; if (err_cnt !== e0) begin n_fail++; $display("FAIL midrst_err: got %0d want 0", err_cnt - e0); end
    good(8'h1C);
    n_cmp++; if (obs_q[o0] !== 10'h01C) begin n_fail++; $display("FAIL midrst_code: got %h want 01c", obs_q[o0]); end
  endtask

  task automatic test_strobe_width();
    n_cmp++; if (cv_wide !== 0) begin n_fail++; $display("FAIL valid_width: got %0d wide strobes want 0", cv_wide); end
    n_cmp++; if (err_wide !== 0) begin n_fail++; $display("FAIL err_width: got %0d wide strobes want 0", err_wide); end
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    send_frame(8'h55, 1'b0, 1'b1, -1, 6);
`ifdef PS2_RX_TIMEOUT_EN
    n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL timeout_pre_state: got %0d want 1", dbg_state); end
    for (int i = 0; i < TIMEOUT_CYC + 200; i++) begin
      if (err_cnt != e0) break;
      tick(1);
    end
    tick(2);
    n_cmp++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL timeout_err: got %0d want 1", err_cnt - e0); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL timeout_state: got %0d want 0", dbg_state); end
`else
    tick(TIMEOUT_CYC + 200);
    n_cmp++; if (err_cnt !== e0) begin n_fail++; $display("FAIL notimeout_err: got %0d want 0", err_cnt - e0); end
    n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL notimeout_state: got %0d want 1", dbg_state); end
`endif
    do_reset();
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_single();
    test_break();
    test_ext_break();
    test_prefix_order();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_midframe_reset();
    test_timeout();
    test_strobe_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive equal synchronized samples required before the filtered ps2_clk level changes.
REQ-002 Parameter TIMEOUT_CYC, default 50000: clk cycles without a falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).
REQ-003 Clock clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 Reset rst, input, 1 bit: synchronous, active-high.
REQ-005 ps2_clk, input, 1 bit: raw PS/2 clock line, asynchronous.
REQ-006 ps2_data, input, 1 bit: raw PS/2 data line, asynchronous.
REQ-007 code, output, 8 bits: last completed non-prefix scancode.
REQ-008 code_valid, output, 1 bit: one-cycle strobe; code/is_break/is_ext are valid when it is high.
REQ-009 is_break, output, 1 bit: an F0 prefix preceded code.
REQ-010 is_ext, output, 1 bit: an E0 prefix preceded code.
REQ-011 frame_err, output, 1 bit: one-cycle strobe on a parity, stop-bit or timeout error.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer; the filtered clock SHALL change level only after FILTER_LEN identical synchronized samples.
REQ-013 A one-cycle falling-edge pulse SHALL be generated on each filtered-clock 1->0 transition; ps2_data SHALL be sampled from its synchronized value on that cycle.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on an edge with data=0 -> DATA with bit count 0; with data=1 -> stay in IDLE, no error.
REQ-016 DATA: shift data in LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: capture the parity bit -> STOP.
REQ-018 STOP: on an edge -> IDLE; the frame is good only if stop=1 and the XOR of the 8 data bits and parity is 1 (odd parity).
REQ-019 A good byte E0 SHALL set ext_pending; F0 SHALL set brk_pending; neither SHALL produce code_valid.
REQ-020 Any other good byte SHALL, one cycle after the stop-bit edge cycle, drive code=byte, is_break=brk_pending, is_ext=ext_pending, and code_valid=1 for exactly one cycle; both pending flags SHALL then clear.
REQ-021 code, is_break and is_ext SHALL hold their values until the next code_valid.
REQ-022 Prefixes SHALL accumulate in any order (E0 F0 or F0 E0); repeated prefixes are idempotent.
REQ-023 A bad frame SHALL pulse frame_err one cycle after the stop edge, clear both pending flags, and emit no code_valid.
REQ-024 E1 and all other bytes SHALL be emitted as ordinary codes.

Reset
REQ-025 On rst: state IDLE; code=0, code_valid=0, is_break=0, is_ext=0, frame_err=0; pending flags, bit count and timeout counter cleared; synchronizer and filter flops set to 1 (idle-high lines).
REQ-026 rst asserted mid-frame SHALL discard the partial frame with no frame_err.

Configuration
REQ-027 Macro PS2_RX_TIMEOUT_EN defined: a counter SHALL run in any non-IDLE state, reset on each edge; on reaching TIMEOUT_CYC -> IDLE, frame_err pulse, pending flags cleared. If the timeout and an edge coincide, the edge SHALL win.
REQ-028 Macro undefined: no counter is built; the FSM waits indefinitely mid-frame, and TIMEOUT_CYC is ignored.

Structure
REQ-029 Package ps2_pkg SHALL hold the FSM state enum and the constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
REQ-030 Sub-module ps2_clk_filter SHALL contain the synchronizers, the filter and the falling-edge pulse generation, and SHALL output the synchronized data and the edge pulse.

Verification
REQ-031 Frame for 0x1C with parity 0 and stop 1 -> one code_valid, code=1C, is_break=0, is_ext=0.
REQ-032 F0 then 1C -> a single code_valid, code=1C, is_break=1; the F0 frame produces no strobe.
REQ-033 E0 F0 75 then 1C -> first strobe code=75, is_ext=1, is_break=1; second strobe code=1C with both flags 0.
REQ-034 Frame 0x29 with a wrong parity bit -> frame_err one cycle, no code_valid; next good 0x29 frame -> code=29.
REQ-035 ps2_clk low glitch of FILTER_LEN-1 cycles during DATA -> no bit sampled; frame completes correctly.
REQ-036 Clock stops after 5 data bits: with PS2_RX_TIMEOUT_EN, frame_err at TIMEOUT_CYC and state IDLE; without it, no frame_err and the FSM stays in DATA.
